// File: rtl/serv_ifetch_pkg.sv
// Shared types and constants for the serv instruction fetch stage.
package serv_ifetch_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  localparam logic [31:0] PC_STEP = 32'd4;

  // Instruction word split: [31:RDT_LSB] to decoders, [RDT_LSB-1:OPC_LSB] opcode
  localparam int unsigned RDT_LSB = 7;
  localparam int unsigned OPC_LSB = 2;

  localparam int unsigned TIMEOUT_DEFAULT = 16;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/serv_ifetch_timer.sv
// Wait-cycle counter for the fetch timeout; expired_o flags the last allowed WAIT cycle.
module serv_ifetch_timer
  import serv_ifetch_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic count_i,
  output logic expired_o
);

  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = '0;
    end else if (count_i) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expiry fires on the WAIT cycle that would make the count reach TIMEOUT_CYCLES
  assign expired_o = count_i && (cnt_q == LAST_COUNT);

endmodule

// File: rtl/serv_ifetch.sv
// Instruction fetch stage: owns the PC and issues Wishbone-classic instruction reads.
// Optional fetch timeout enabled by defining SERV_IFETCH_TIMEOUT_EN.
module serv_ifetch
  import serv_ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_fetch_req,
  input  logic        i_pc_wr,
  input  logic [31:0] i_pc_wdata,
  output logic [31:0] o_ibus_adr,
  output logic        o_ibus_cyc,
  input  logic [31:0] i_ibus_rdt,
  input  logic        i_ibus_ack,
  output logic        o_wb_en,
  output logic [24:0] o_wb_rdt,
  output logic [4:0]  o_opcode,
  output logic        o_illegal,
  output logic        o_busy,
  output logic [31:0] o_pc,
  output logic        o_timeout
);

  if ((TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES > 255)) begin : g_bad_timeout
    $error("serv_ifetch: TIMEOUT_CYCLES out of range 2..255");
  end

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] adr_q;
  logic [24:0] rdt_q;
  logic [4:0]  opcode_q;
  logic        illegal_q;
  logic        wb_en_q;
  logic        timeout_q;

  logic [31:0] fetch_pc_d;
  logic        expired;

  // A PC write in the same cycle as a request is forwarded to the fetch address
  assign fetch_pc_d = i_pc_wr ? align_pc(i_pc_wdata) : pc_q;

`ifdef SERV_IFETCH_TIMEOUT_EN
  serv_ifetch_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i     (i_clk),
    .rst_i     (i_rst),
    .start_i   ((state_q == S_IDLE) && i_fetch_req),
    .count_i   ((state_q == S_WAIT) && !i_ibus_ack),
    .expired_o (expired)
  );
`else
  assign expired = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      pc_q      <= align_pc(RESET_PC);
      adr_q     <= align_pc(RESET_PC);
      rdt_q     <= '0;
      opcode_q  <= '0;
      illegal_q <= 1'b0;
      wb_en_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      wb_en_q   <= 1'b0;
      timeout_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (i_pc_wr) begin
            pc_q <= align_pc(i_pc_wdata);
          end
          if (i_fetch_req) begin
            adr_q   <= fetch_pc_d;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (i_ibus_ack) begin
            rdt_q     <= i_ibus_rdt[31:RDT_LSB];
            opcode_q  <= i_ibus_rdt[RDT_LSB-1:OPC_LSB];
            illegal_q <= (i_ibus_rdt[1:0] != 2'b11);
            pc_q      <= pc_q + PC_STEP;
            wb_en_q   <= 1'b1;
            state_q   <= S_IDLE;
          end else if (expired) begin
            timeout_q <= 1'b1;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_ibus_adr = adr_q;
  assign o_ibus_cyc = (state_q == S_WAIT);
  assign o_busy     = (state_q == S_WAIT);
  assign o_wb_en    = wb_en_q;
  assign o_wb_rdt   = rdt_q;
  assign o_opcode   = opcode_q;
  assign o_illegal  = illegal_q;
  assign o_pc       = pc_q;
  assign o_timeout  = timeout_q;

endmodule

// File: tb/tb_serv_ifetch.sv
// Self-checking bench for serv_ifetch: directed vector table, corner sequences, random vs model.
module tb_serv_ifetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int unsigned TO_CYC = 16;
`ifdef SERV_IFETCH_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req;
  logic        pc_wr;
  logic [31:0] pc_wdata;
  logic [31:0] ibus_adr;
  logic        ibus_cyc;
  logic [31:0] ibus_rdt;
  logic        ibus_ack;
  logic        wb_en;
  logic [24:0] wb_rdt;
  logic [4:0]  opcode;
  logic        illegal;
  logic        busy;
  logic [31:0] pc;
  logic        timeout;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serv_ifetch #(
    .RESET_PC       (RST_PC),
    .TIMEOUT_CYCLES (TO_CYC)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_fetch_req (fetch_req),
    .i_pc_wr     (pc_wr),
    .i_pc_wdata  (pc_wdata),
    .o_ibus_adr  (ibus_adr),
    .o_ibus_cyc  (ibus_cyc),
    .i_ibus_rdt  (ibus_rdt),
    .i_ibus_ack  (ibus_ack),
    .o_wb_en     (wb_en),
    .o_wb_rdt    (wb_rdt),
    .o_opcode    (opcode),
    .o_illegal   (illegal),
    .o_busy      (busy),
    .o_pc        (pc),
    .o_timeout   (timeout)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fetch_req = 1'b0;
    pc_wr     = 1'b0;
    pc_wdata  = '0;
    ibus_ack  = 1'b0;
    ibus_rdt  = '0;
  endtask

  // Reference model: instruction-level view of the fetch stage
  logic        m_busy;
  logic [31:0] m_pc, m_adr;
  logic [31:0] m_word;
  logic        m_wb, m_to;
  int unsigned m_wait;

  task automatic model_reset();
    m_busy = 1'b0; m_pc = RST_PC; m_adr = RST_PC; m_word = 32'h0000_0003;
    m_wb = 1'b0; m_to = 1'b0; m_wait = 0;
  endtask

  task automatic model_step();
    m_wb = 1'b0;
    m_to = 1'b0;
    if (m_busy) begin
      if (ibus_ack) begin
        m_word = ibus_rdt;
        m_pc   = m_pc + 32'd4;
        m_wb   = 1'b1;
        m_busy = 1'b0;
      end else begin
        m_wait++;
        if (TO_EN && m_wait == TO_CYC) begin
          m_busy = 1'b0;
          m_to   = 1'b1;
        end
      end
    end else begin
      if (pc_wr) m_pc = pc_wdata & ~32'd3;
      if (fetch_req) begin
        m_adr  = m_pc;
        m_busy = 1'b1;
        m_wait = 0;
      end
    end
  endtask

  task automatic model_compare(input string tag);
    chk({tag, ".cyc"}, {31'd0, ibus_cyc}, {31'd0, m_busy});
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, m_busy});
    chk({tag, ".pc"}, pc, m_pc);
    if (m_busy) chk({tag, ".adr"}, ibus_adr, m_adr);
    chk({tag, ".wb_en"}, {31'd0, wb_en}, {31'd0, m_wb});
    chk({tag, ".timeout"}, {31'd0, timeout}, {31'd0, m_to});
    chk({tag, ".wb_rdt"}, {7'd0, wb_rdt}, m_word >> 7);
    chk({tag, ".opcode"}, {27'd0, opcode}, (m_word >> 2) & 32'h1F);
    chk({tag, ".illegal"}, {31'd0, illegal}, {31'd0, (m_word % 4) != 3});
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst.cyc", {31'd0, ibus_cyc}, 32'd0);
      chk("rst.wb_en", {31'd0, wb_en}, 32'd0);
      chk("rst.pc", pc, RST_PC);
    end
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic        fetch;
    logic        wr;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdt;
    logic        cyc;
    logic        wb;
    logic [31:0] pc;
    logic [31:0] adr;
    logic [24:0] wrdt;
    logic [4:0]  op;
    logic        ill;
  } vec_t;

  vec_t vecs[11];

  initial begin
    rst = 1'b1;
    idle_inputs();

    vecs[0]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         32'h0,         25'h0,       5'h00, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         32'h0,         25'h0,       5'h00, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         32'h0,         25'h0,       5'h00, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'hABCDE193,  1'b0, 1'b1, 32'h4,         32'h0,         25'h1579BC3, 5'h04, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 32'h00000083,  1'b0, 32'h0,         1'b1, 1'b0, 32'h80,        32'h80,        25'h1579BC3, 5'h04, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h00000001,  1'b0, 1'b1, 32'h84,        32'h80,        25'h0,       5'h00, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 32'hFFFFFFFE,  1'b0, 32'h0,         1'b0, 1'b0, 32'hFFFFFFFC,  32'h80,        25'h0,       5'h00, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b0, 32'hFFFFFFFC,  32'hFFFFFFFC,  25'h0,       5'h00, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 32'h00000100,  1'b0, 32'h0,         1'b1, 1'b0, 32'hFFFFFFFC,  32'hFFFFFFFC,  25'h0,       5'h00, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h00000013,  1'b0, 1'b1, 32'h0,         32'hFFFFFFFC,  25'h0,       5'h04, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'hFFFFFFFF,  1'b0, 1'b0, 32'h0,         32'hFFFFFFFC,  25'h0,       5'h04, 1'b0};

    do_reset();

    for (int v = 0; v < 11; v++) begin
      fetch_req = vecs[v].fetch;
      pc_wr     = vecs[v].wr;
      pc_wdata  = vecs[v].wdata;
      ibus_ack  = vecs[v].ack;
      ibus_rdt  = vecs[v].rdt;
      tick();
      chk($sformatf("vec%0d.cyc", v), {31'd0, ibus_cyc}, {31'd0, vecs[v].cyc});
      chk($sformatf("vec%0d.wb_en", v), {31'd0, wb_en}, {31'd0, vecs[v].wb});
      chk($sformatf("vec%0d.pc", v), pc, vecs[v].pc);
      chk($sformatf("vec%0d.adr", v), ibus_adr, vecs[v].adr);
      chk($sformatf("vec%0d.wb_rdt", v), {7'd0, wb_rdt}, {7'd0, vecs[v].wrdt});
      chk($sformatf("vec%0d.opcode", v), {27'd0, opcode}, {27'd0, vecs[v].op});
      chk($sformatf("vec%0d.illegal", v), {31'd0, illegal}, {31'd0, vecs[v].ill});
      chk($sformatf("vec%0d.timeout", v), {31'd0, timeout}, 32'd0);
    end
    idle_inputs();

    // Reset while waiting, with an ack landing in the same cycle
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    chk("rstwait.cyc_before", {31'd0, ibus_cyc}, 32'd1);
    rst = 1'b1; ibus_ack = 1'b1; ibus_rdt = 32'h1234_5677;
    tick();
    rst = 1'b0; ibus_ack = 1'b0;
    chk("rstwait.cyc", {31'd0, ibus_cyc}, 32'd0);
    chk("rstwait.wb_en", {31'd0, wb_en}, 32'd0);
    chk("rstwait.pc", pc, RST_PC);
    chk("rstwait.wb_rdt", {7'd0, wb_rdt}, 32'd0);
    tick();
    chk("rstwait.wb_en_late", {31'd0, wb_en}, 32'd0);

    // Long wait with no acknowledge
    pc_wr = 1'b1; pc_wdata = 32'h0000_0400; fetch_req = 1'b1;
    tick();
    pc_wr = 1'b0; fetch_req = 1'b0;
    for (int i = 0; i < TO_CYC; i++) begin
      chk($sformatf("to.cyc_w%0d", i), {31'd0, ibus_cyc}, 32'd1);
      chk($sformatf("to.pulse_w%0d", i), {31'd0, timeout}, 32'd0);
      tick();
    end
    if (TO_EN) begin
      chk("to.pulse", {31'd0, timeout}, 32'd1);
      chk("to.cyc_drop", {31'd0, ibus_cyc}, 32'd0);
      chk("to.pc", pc, 32'h0000_0400);
      chk("to.wb_en", {31'd0, wb_en}, 32'd0);
      ibus_ack = 1'b1; ibus_rdt = 32'hFFFF_FFFF;
      tick();
      ibus_ack = 1'b0;
      chk("to.pulse_once", {31'd0, timeout}, 32'd0);
      chk("to.late_ack_wb", {31'd0, wb_en}, 32'd0);
      chk("to.late_ack_pc", pc, 32'h0000_0400);
    end else begin
      for (int i = 0; i < 24; i++) begin
        chk("nto.cyc_held", {31'd0, ibus_cyc}, 32'd1);
        chk("nto.timeout", {31'd0, timeout}, 32'd0);
        tick();
      end
      ibus_ack = 1'b1; ibus_rdt = 32'h0000_0033;
      tick();
      ibus_ack = 1'b0;
      chk("nto.wb_en", {31'd0, wb_en}, 32'd1);
      chk("nto.pc", pc, 32'h0000_0404);
    end

    // Randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      fetch_req = ($urandom_range(0, 2) != 0);
      pc_wr     = ($urandom_range(0, 3) == 0);
      pc_wdata  = (i % 97 == 0) ? 32'hFFFF_FFFF : $urandom;
      ibus_rdt  = $urandom;
      if (m_busy) ibus_ack = (i >= 1000 && i < 1800) ? ($urandom_range(0, 24) == 0)
                                                     : ($urandom_range(0, 2) == 0);
      else        ibus_ack = ($urandom_range(0, 5) == 0);
      model_step();
      tick();
      model_compare($sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
